// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin snooping bus arbiter for N MESI caches.
// One transaction at a time: optional victim writeback, broadcast, snoop, owner or memory phase, ack.
module snoop_bus_arbiter #(
  parameter int N_CACHES = 2,
  parameter int ADDR_W   = 8,
  parameter int MEM_LAT  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_CACHES-1:0]          req,
  input  logic [2*N_CACHES-1:0]        req_bus,
  input  logic [ADDR_W*N_CACHES-1:0]   req_addr,
  input  logic [N_CACHES-1:0]          req_wb,
  output logic                         snoop_valid,
  output logic [1:0]                   snoop_bus,
  output logic [ADDR_W-1:0]            snoop_addr,
  output logic [N_CACHES-1:0]          snoop_src,
  input  logic [N_CACHES-1:0]          snoop_hit,
  input  logic [N_CACHES-1:0]          snoop_wb,
  input  logic [N_CACHES-1:0]          snoop_abort,
  output logic                         mem_rd,
  output logic                         mem_wr,
  output logic [N_CACHES-1:0]          ack,
  output logic                         shared_out,
  output logic                         err
);
  localparam int GW = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [2:0] {IDLE, VWB, BCAST, SNOOP, OWB, MEM, DONE} state_t;
  state_t              state_q;
  logic [GW-1:0]       gnt_q, last_q, pick;
  logic [1:0]          code_q, pick_code;
  logic [ADDR_W-1:0]   addr_q, saddr_q;
  logic [CW-1:0]       cnt_q;
  logic                shared_q, found;
  logic [N_CACHES-1:0] gnt_oh, mask;
  logic                unused_snoop_wb;
  assign gnt_oh    = N_CACHES'(1) << gnt_q;
  assign mask      = ~gnt_oh;
  assign pick_code = req_bus[2*pick +: 2];
  // Round-robin search starting just after the last granted cache.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int k = 1; k <= N_CACHES; k++) begin
      if (!found && req[GW'((int'(last_q) + k) % N_CACHES)]) begin
        pick  = GW'((int'(last_q) + k) % N_CACHES);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      last_q   <= GW'(N_CACHES - 1);
      code_q   <= '0;
      addr_q   <= '0;
      saddr_q  <= '0;
      cnt_q    <= '0;
      shared_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          gnt_q   <= pick;
          code_q  <= pick_code;
          addr_q  <= req_addr[ADDR_W*pick +: ADDR_W];
          cnt_q   <= CW'(MEM_LAT - 1);
          state_q <= (pick_code == 2'b00) ? DONE : req_wb[pick] ? VWB : BCAST;
        end
        VWB: begin
          cnt_q   <= cnt_q - 1'b1;
          state_q <= (cnt_q == '0) ? BCAST : VWB;
        end
        BCAST: begin
          saddr_q <= addr_q;
          state_q <= SNOOP;
        end
        SNOOP: begin
          shared_q <= |(snoop_hit & mask);
          cnt_q    <= CW'(MEM_LAT - 1);
          state_q  <= (code_q == 2'b11) ? DONE : (|(snoop_abort & mask)) ? OWB : MEM;
        end
        OWB, MEM: begin
          cnt_q   <= cnt_q - 1'b1;
          state_q <= (cnt_q == '0) ? DONE : state_q;
        end
        DONE: begin
          last_q  <= gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Only snoop_abort marks an owner; a writeback reply alone changes nothing here.
  assign unused_snoop_wb = ^snoop_wb;
  assign snoop_valid = state_q == BCAST;
  assign snoop_bus   = snoop_valid ? code_q : 2'b00;
  assign snoop_addr  = snoop_valid ? addr_q : saddr_q;
  assign snoop_src   = snoop_valid ? gnt_oh : '0;
  assign mem_rd      = state_q == MEM;
  assign mem_wr      = (state_q == VWB) || (state_q == OWB);
  assign ack         = (state_q == DONE) ? gnt_oh : '0;
  assign shared_out  = (state_q == DONE) && (code_q == 2'b01) && shared_q;
  assign err         = (state_q == DONE) && (code_q == 2'b00);
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed and random transactions checked against a
// transaction-level model of grant order, phase lengths, latency and flags.
module tb_snoop_bus_arbiter;
  localparam int N = 2, AW = 8, L = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, req_wb = '0, snoop_hit = '0, snoop_wb = '0, snoop_abort = '0;
  logic [2*N-1:0] req_bus = '0;
  logic [AW*N-1:0] req_addr = '0;
  logic snoop_valid, mem_rd, mem_wr, shared_out, err;
  logic [1:0] snoop_bus;
  logic [AW-1:0] snoop_addr;
  logic [N-1:0] snoop_src, ack;
  int npass = 0, nchk = 0, last_g = N - 1;

  always #5 clk = ~clk;

  snoop_bus_arbiter #(.N_CACHES(N), .ADDR_W(AW), .MEM_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_bus(req_bus), .req_addr(req_addr),
    .req_wb(req_wb), .snoop_valid(snoop_valid), .snoop_bus(snoop_bus),
    .snoop_addr(snoop_addr), .snoop_src(snoop_src), .snoop_hit(snoop_hit),
    .snoop_wb(snoop_wb), .snoop_abort(snoop_abort), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ack(ack), .shared_out(shared_out), .err(err)
  );

  initial begin
    #300000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(last_g + k) % N]) return (last_g + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] c, input logic [AW-1:0] a, input logic w);
    req[i] = 1'b1;
    req_bus[2*i +: 2] = c;
    req_addr[AW*i +: AW] = a;
    req_wb[i] = w;
  endtask

  function automatic int outs_vec();
    return int'({snoop_valid, snoop_bus, snoop_src, mem_rd, mem_wr, ack, shared_out, err});
  endfunction

  // Called at a negedge with the DUT idle; the next posedge is the grant edge.
  task automatic txn(input string tag, input logic [N-1:0] hit, input logic [N-1:0] swb, input logic [N-1:0] ab);
    int g, lat = 0, nv = 0, nrd = 0, nwr = 0, both = 0, nerr = 0, badbus = 0;
    int vcyc = 0, busv = 0, srcv = 0, addrv = 0, ackv = 0, shv = 0, errv = 0;
    int exp_lat, exp_rd, exp_wr;
    logic [1:0] c;
    logic [AW-1:0] a;
    logic w, owner, sh;
    logic [N-1:0] others;
    g = rr_pick(req);
    if (g < 0) begin
      chk({tag, ".noreq"}, 0, 1);
      return;
    end
    c = req_bus[2*g +: 2];
    a = req_addr[AW*g +: AW];
    w = req_wb[g];
    snoop_hit = hit;
    snoop_wb = swb;
    snoop_abort = ab;
    others = ~(N'(1) << g);
    owner = |(ab & others);
    sh = |(hit & others);
    exp_lat = (c == 2'b00) ? 1 : 3 + (w ? L : 0) + ((c == 2'b11) ? 0 : L);
    exp_wr  = (c == 2'b00) ? 0 : (w ? L : 0) + ((c != 2'b11 && owner) ? L : 0);
    exp_rd  = ((c == 2'b01 || c == 2'b10) && !owner) ? L : 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      nv += int'(snoop_valid);
      if (snoop_valid) begin
        vcyc = k; busv = int'(snoop_bus); srcv = int'(snoop_src); addrv = int'(snoop_addr);
      end else if (snoop_bus != 2'b00) badbus++;
      nrd += int'(mem_rd);
      nwr += int'(mem_wr);
      if (mem_rd && mem_wr) both++;
      nerr += int'(err);
      if (ack != '0) begin
        lat = k; ackv = int'(ack); shv = int'(shared_out); errv = int'(err);
        break;
      end
    end
    chk({tag, ".ack"}, ackv, 1 << g);
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".nvalid"}, nv, (c != 2'b00) ? 1 : 0);
    chk({tag, ".mem_rd_cycles"}, nrd, exp_rd);
    chk({tag, ".mem_wr_cycles"}, nwr, exp_wr);
    chk({tag, ".rd_wr_overlap"}, both, 0);
    chk({tag, ".idle_bus"}, badbus, 0);
    chk({tag, ".shared"}, shv, (c == 2'b01 && sh) ? 1 : 0);
    chk({tag, ".err_at_ack"}, errv, (c == 2'b00) ? 1 : 0);
    chk({tag, ".err_cycles"}, nerr, (c == 2'b00) ? 1 : 0);
    if (c != 2'b00) begin
      chk({tag, ".bcast_cycle"}, vcyc, (w ? L : 0) + 1);
      chk({tag, ".bcast_bus"}, busv, int'(c));
      chk({tag, ".bcast_src"}, srcv, 1 << g);
      chk({tag, ".bcast_addr"}, addrv, int'(a));
    end
    req[g] = 1'b0;
    last_g = g;
    @(negedge clk);
    if (c != 2'b00) chk({tag, ".addr_hold"}, int'(snoop_addr), int'(a));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset.outputs", outs_vec(), 0);
    chk("reset.addr", int'(snoop_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    set_req(0, 2'b01, 8'h12, 1'b0);
    txn("rd0", '0, '0, '0);
    set_req(1, 2'b01, 8'h34, 1'b0);
    txn("rd1_owner", 2'b01, 2'b01, 2'b01);
    set_req(0, 2'b11, 8'h56, 1'b0);
    txn("inv0", 2'b10, '0, '0);

    set_req(0, 2'b01, 8'h21, 1'b0);
    set_req(1, 2'b10, 8'h43, 1'b0);
    for (int j = 0; j < 4; j++) begin
      txn("rr", N'($urandom), N'($urandom), N'($urandom));
      if (j < 2) set_req(last_g, 2'($urandom_range(1, 3)), AW'($urandom), 1'b0);
    end

    set_req(1, 2'b10, 8'h78, 1'b1);
    txn("wm_wb", '0, '0, '0);

    set_req(1, 2'b01, 8'h9A, 1'b0);
    for (int k = 0; k < 20 && !mem_rd; k++) @(negedge clk);
    chk("rst_mid.saw_mem_rd", int'(mem_rd), 1);
    set_req(0, 2'b01, 8'hBC, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.outputs", outs_vec(), 0);
    @(negedge clk);
    chk("rst_mid.no_ack", int'(ack), 0);
    last_g = N - 1;
    rst_n = 1'b1;
    txn("after_rst0", '0, '0, '0);
    txn("after_rst1", 2'b01, '0, '0);

    set_req(0, 2'b00, 8'hEE, 1'b1);
    txn("illegal", 2'b10, 2'b10, 2'b10);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_req(i, 2'($urandom), AW'($urandom), 1'($urandom));
      if (req == '0) set_req(int'($urandom_range(0, N - 1)), 2'($urandom), AW'($urandom), 1'($urandom));
      txn("rand", N'($urandom), N'($urandom), N'($urandom));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
